// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divisibility checker.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Remainder width: enough bits for 0..DIVISOR-1, never less than one.
  function automatic int calc_rw(input int divisor);
    int w;
    w = $clog2(divisor);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/div_check_seq_mod_step.sv
// One MSB-first reduction step: folds a CHUNK-bit digit into a running remainder.
module mod_step #(
  parameter int DIVISOR = 3,
  parameter int CHUNK   = 4,
  parameter int RW      = 2
) (
  input  logic [RW-1:0]    rem_in,
  input  logic [CHUNK-1:0] chunk,
  output logic [RW-1:0]    rem_out
);

  localparam int AW = RW + CHUNK;
  localparam logic [AW-1:0] DIV_W = AW'(DIVISOR);

  logic [AW-1:0] acc_s;

  // Full-width concatenation so the mod sees every bit before any truncation.
  assign acc_s   = {rem_in, chunk};
  assign rem_out = RW'(acc_s % DIV_W);

endmodule

// File: rtl/div_check_seq.sv
// Sequential divisible-by-DIVISOR checker: CHUNK bits per clock, MSB first,
// with valid/ready handshakes on the operand and on the result.
module div_check_seq
  import div_pkg::*;
#(
  parameter  int WIDTH   = 16,
  parameter  int DIVISOR = 3,
  parameter  int CHUNK   = 4,
  localparam int RW      = calc_rw(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_number,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RW-1:0]    out_remainder,
  output logic             out_divisible
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  if ((WIDTH % CHUNK) != 0 || DIVISOR < 2 || CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_params
    $error("div_check_seq: WIDTH must be a multiple of CHUNK, 1<=CHUNK<=WIDTH, DIVISOR>=2");
  end

  state_t           state_r;
  logic [WIDTH-1:0] shift_r;
  logic [CW-1:0]    cnt_r;
  logic [RW-1:0]    rem_r;
  logic [RW-1:0]    rem_next_s;

  mod_step #(
    .DIVISOR (DIVISOR),
    .CHUNK   (CHUNK),
    .RW      (RW)
  ) u_step (
    .rem_in  (rem_r),
    .chunk   (shift_r[WIDTH-1 -: CHUNK]),
    .rem_out (rem_next_s)
  );

  // Control FSM, digit shifter, step counter and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_remainder <= '0;
      out_divisible <= 1'b0;
      shift_r       <= '0;
      cnt_r         <= '0;
      rem_r         <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            shift_r  <= in_number;
            rem_r    <= '0;
            cnt_r    <= '0;
            in_ready <= 1'b0;
            state_r  <= RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          rem_r   <= rem_next_s;
          shift_r <= shift_r << CHUNK;
          cnt_r   <= cnt_r + CW'(1);
          // The last digit's remainder goes straight to the output register.
          if (cnt_r == CW'(NCH - 1)) begin
            out_remainder <= rem_next_s;
            out_divisible <= (rem_next_s == RW'(0));
            out_valid     <= 1'b1;
            state_r       <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_check_seq.sv
// Randomised self-checking bench for div_check_seq at three parameter sets.
module tb_div_check_seq;

  logic clk;
  logic rst;

  // Instance a: 16/3/4
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_divisible;
  logic [15:0] a_in_number;
  logic [1:0]  a_out_remainder;
  // Instance b: 16/7/1
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_divisible;
  logic [15:0] b_in_number;
  logic [2:0]  b_out_remainder;
  // Instance c: 8/3/8
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_divisible;
  logic [7:0]  c_in_number;
  logic [1:0]  c_out_remainder;

  int n_checks = 0;
  int n_fail   = 0;

  div_check_seq #(.WIDTH(16), .DIVISOR(3), .CHUNK(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_number(a_in_number), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_remainder(a_out_remainder), .out_divisible(a_out_divisible));

  div_check_seq #(.WIDTH(16), .DIVISOR(7), .CHUNK(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_number(b_in_number), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_remainder(b_out_remainder), .out_divisible(b_out_divisible));

  div_check_seq #(.WIDTH(8), .DIVISOR(3), .CHUNK(8)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_number(c_in_number), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_remainder(c_out_remainder), .out_divisible(c_out_divisible));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full transaction on instance a; the result must equal n mod 3 after 4 cycles.
  task automatic run_a(input logic [15:0] n, input int hold, input int gap, input bit poke, input string tag);
    int k;
    logic [1:0] exp_rem;
    logic exp_div;
    exp_rem = 2'(int'(n) % 3);
    exp_div = (exp_rem == 2'd0);
    repeat (gap) @(negedge clk);
    a_in_number = n;
    a_in_valid  = 1'b1;
    k = 0;
    while (!a_in_ready && k < 50) begin @(negedge clk); k++; end
    n_checks++;
    if (a_in_ready !== 1'b1) begin $display("FAIL %s ready: got %b want 1", tag, a_in_ready); n_fail++; end
    @(posedge clk);
    @(negedge clk);
    a_in_valid  = 1'b0;
    a_in_number = 16'($urandom);
    k = 0;
    while (a_out_valid !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    n_checks++;
    if (k !== 4) begin $display("FAIL %s latency: got %0d want 4", tag, k); n_fail++; end
    n_checks++;
    if (a_out_remainder !== exp_rem) begin $display("FAIL %s rem n=%h: got %0d want %0d", tag, n, a_out_remainder, exp_rem); n_fail++; end
    n_checks++;
    if (a_out_divisible !== exp_div) begin $display("FAIL %s div n=%h: got %b want %b", tag, n, a_out_divisible, exp_div); n_fail++; end
    for (int i = 0; i < hold; i++) begin
      if (poke) begin a_in_valid = 1'b1; a_in_number = 16'h0003; end
      @(negedge clk);
      n_checks++;
      if ({a_out_valid, a_in_ready, a_out_remainder, a_out_divisible} !== {1'b1, 1'b0, exp_rem, exp_div}) begin
        $display("FAIL %s hold%0d: got v=%b r=%b rem=%0d d=%b want v=1 r=0 rem=%0d d=%b",
                 tag, i, a_out_valid, a_in_ready, a_out_remainder, a_out_divisible, exp_rem, exp_div);
        n_fail++;
      end
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    n_checks++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin $display("FAIL %s release: got v=%b r=%b want v=0 r=1", tag, a_out_valid, a_in_ready); n_fail++; end
  endtask

  // One transaction on instance b; result must equal n mod 7 after 16 cycles.
  task automatic run_b(input logic [15:0] n, input int hold, input int gap, input string tag);
    int k;
    logic [2:0] exp_rem;
    exp_rem = 3'(int'(n) % 7);
    repeat (gap) @(negedge clk);
    b_in_number = n;
    b_in_valid  = 1'b1;
    k = 0;
    while (!b_in_ready && k < 50) begin @(negedge clk); k++; end
    n_checks++;
    if (b_in_ready !== 1'b1) begin $display("FAIL %s ready: got %b want 1", tag, b_in_ready); n_fail++; end
    @(posedge clk);
    @(negedge clk);
    b_in_valid  = 1'b0;
    b_in_number = 16'($urandom);
    k = 0;
    while (b_out_valid !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    n_checks++;
    if (k !== 16) begin $display("FAIL %s latency: got %0d want 16", tag, k); n_fail++; end
    n_checks++;
    if ({b_out_remainder, b_out_divisible} !== {exp_rem, exp_rem == 3'd0}) begin
      $display("FAIL %s result n=%h: got rem=%0d d=%b want rem=%0d d=%b", tag, n, b_out_remainder, b_out_divisible, exp_rem, exp_rem == 3'd0);
      n_fail++;
    end
    repeat (hold) @(negedge clk);
    n_checks++;
    if ({b_out_valid, b_out_remainder} !== {1'b1, exp_rem}) begin $display("FAIL %s hold: got v=%b rem=%0d want v=1 rem=%0d", tag, b_out_valid, b_out_remainder, exp_rem); n_fail++; end
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    n_checks++;
    if ({b_out_valid, b_in_ready} !== 2'b01) begin $display("FAIL %s release: got v=%b r=%b want v=0 r=1", tag, b_out_valid, b_in_ready); n_fail++; end
  endtask

  // One transaction on instance c; a single RUN cycle, result n mod 3.
  task automatic run_c(input logic [7:0] n, input int hold, input int gap, input string tag);
    int k;
    logic [1:0] exp_rem;
    exp_rem = 2'(int'(n) % 3);
    repeat (gap) @(negedge clk);
    c_in_number = n;
    c_in_valid  = 1'b1;
    k = 0;
    while (!c_in_ready && k < 50) begin @(negedge clk); k++; end
    n_checks++;
    if (c_in_ready !== 1'b1) begin $display("FAIL %s ready: got %b want 1", tag, c_in_ready); n_fail++; end
    @(posedge clk);
    @(negedge clk);
    c_in_valid  = 1'b0;
    c_in_number = 8'($urandom);
    k = 0;
    while (c_out_valid !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    n_checks++;
    if (k !== 1) begin $display("FAIL %s latency: got %0d want 1", tag, k); n_fail++; end
    n_checks++;
    if ({c_out_remainder, c_out_divisible} !== {exp_rem, exp_rem == 2'd0}) begin
      $display("FAIL %s result n=%h: got rem=%0d d=%b want rem=%0d d=%b", tag, n, c_out_remainder, c_out_divisible, exp_rem, exp_rem == 2'd0);
      n_fail++;
    end
    repeat (hold) @(negedge clk);
    n_checks++;
    if ({c_out_valid, c_out_remainder} !== {1'b1, exp_rem}) begin $display("FAIL %s hold: got v=%b rem=%0d want v=1 rem=%0d", tag, c_out_valid, c_out_remainder, exp_rem); n_fail++; end
    c_out_ready = 1'b1;
    @(negedge clk);
    c_out_ready = 1'b0;
    n_checks++;
    if ({c_out_valid, c_in_ready} !== 2'b01) begin $display("FAIL %s release: got v=%b r=%b want v=0 r=1", tag, c_out_valid, c_in_ready); n_fail++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({a_in_ready, a_out_valid, a_out_remainder, a_out_divisible} !== {1'b1, 1'b0, 2'd0, 1'b0}) begin
      $display("FAIL reset_a: got r=%b v=%b rem=%0d d=%b want r=1 v=0 rem=0 d=0", a_in_ready, a_out_valid, a_out_remainder, a_out_divisible);
      n_fail++;
    end
    n_checks++;
    if ({b_in_ready, b_out_valid, b_out_remainder, c_in_ready, c_out_valid, c_out_remainder} !== {1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 2'd0}) begin
      $display("FAIL reset_bc: got b r=%b v=%b rem=%0d c r=%b v=%b rem=%0d", b_in_ready, b_out_valid, b_out_remainder, c_in_ready, c_out_valid, c_out_remainder);
      n_fail++;
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_a(16'h0009, 0, 0, 1'b0, "dir_0009");
    run_a(16'hFFFF, 0, 1, 1'b0, "dir_ffff");
    run_a(16'h0007, 0, 0, 1'b0, "dir_0007");
    run_a(16'hFFFE, 1, 0, 1'b0, "dir_fffe");
    run_a(16'h0000, 0, 2, 1'b0, "dir_0000");
  endtask

  task automatic test_backpressure();
    run_a(16'h000A, 10, 0, 1'b1, "backpressure");
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    a_in_number = 16'h1234;
    a_in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({a_in_ready, a_out_valid} !== 2'b10) begin $display("FAIL midrun_reset: got r=%b v=%b want r=1 v=0", a_in_ready, a_out_valid); n_fail++; end
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (a_out_valid !== 1'b0) seen = 1'b1; end
    n_checks++;
    if (seen !== 1'b0) begin $display("FAIL midrun_ghost: got out_valid seen=%b want 0", seen); n_fail++; end
    // rst together with in_valid: the operand must not be taken
    rst         = 1'b1;
    a_in_valid  = 1'b1;
    a_in_number = 16'h0005;
    @(negedge clk);
    rst        = 1'b0;
    a_in_valid = 1'b0;
    n_checks++;
    if ({a_in_ready, a_out_valid} !== 2'b10) begin $display("FAIL rst_vs_valid: got r=%b v=%b want r=1 v=0", a_in_ready, a_out_valid); n_fail++; end
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (a_out_valid !== 1'b0) seen = 1'b1; end
    n_checks++;
    if (seen !== 1'b0) begin $display("FAIL rst_vs_valid_ghost: got out_valid seen=%b want 0", seen); n_fail++; end
    run_a(16'h0006, 0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_params();
    run_b(16'h0031, 0, 0, "d7_0031");
    run_b(16'h0032, 2, 0, "d7_0032");
    run_b(16'hFFFF, 0, 1, "d7_ffff");
    run_c(8'hFF, 0, 0, "w8_ff");
    run_c(8'h00, 1, 0, "w8_00");
    run_c(8'h80, 0, 1, "w8_80");
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++)
      run_a(16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), "rand_a");
    for (int i = 0; i < 1000; i++)
      run_b(16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), "rand_b");
    for (int i = 0; i < 1000; i++)
      run_c(8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), "rand_c");
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_number = 16'h0000; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_number = 16'h0000; b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_number = 8'h00;    c_out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_params();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
